// File: rtl/alu_pkg.sv
// Shared types and constants for the reversible-gate ALU carry/sum stage.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int SLICE_DEF = 2;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
  localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Slice-index width; a single-slice build still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_carry_sum_unit_carry_slice.sv
// carry_slice: combinational SLICE-bit ripple of the generate/propagate chain.
module carry_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  input  logic             m,
  output logic [SLICE-1:0] f,
  output logic             cout,
  output logic             ctop
);

  logic [SLICE:0] c_s;

  // Ripple through the slice; logic mode kills every carry including the incoming one.
  always_comb begin
    c_s    = '0;
    c_s[0] = cin & ~m;
    for (int i = 0; i < SLICE; i++) begin
      c_s[i+1] = (y[i] | (x[i] & c_s[i])) & ~m;
    end
  end

  assign f    = x ^ c_s[SLICE-1:0];
  assign cout = c_s[SLICE];
  assign ctop = c_s[SLICE-1];

endmodule

// File: rtl/alu_carry_sum_unit.sv
// Registered carry/sum stage: serial SLICE-per-clock carry walk, valid/ready in and out.
// Define ALU_LOOKAHEAD_EN to resolve the whole chain on the accepting edge instead.
module alu_carry_sum_unit import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int N_SLC    = WIDTH / SLICE;
  localparam int IDX_BITS = idx_width(N_SLC);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_SLC - 1);

`ifdef ALU_LOOKAHEAD_EN
  localparam state_t ACCEPT_ST = DONE;
`else
  localparam state_t ACCEPT_ST = RUN;
`endif

  state_t              state_r;
  state_t              state_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [WIDTH-1:0]    x_r;
  logic [WIDTH-1:0]    y_r;
  logic [WIDTH-1:0]    f_r;
  logic                m_r;
  logic                carry_r;
  logic                cout_r;
  logic                zero_r;
  logic                ovf_r;
  logic [IDX_BITS-1:0] idx_r;
  logic                accept_s;
  logic [WIDTH-1:0]    f_res_s;
  logic                cout_res_s;
  logic                ovf_res_s;

  assign accept_s = in_valid & in_ready_r;

`ifdef ALU_LOOKAHEAD_EN
  logic [N_SLC:0]   c_la_s;
  logic [N_SLC-1:0] ctop_la_s;

  assign c_la_s[0] = (m == MODE_LOGIC) ? 1'b0 : cin;

  for (genvar g = 0; g < N_SLC; g++) begin : g_la
    carry_slice #(.SLICE(SLICE)) u_slice (
      .x    (x[g*SLICE +: SLICE]),
      .y    (y[g*SLICE +: SLICE]),
      .cin  (c_la_s[g]),
      .m    (m),
      .f    (f_res_s[g*SLICE +: SLICE]),
      .cout (c_la_s[g+1]),
      .ctop (ctop_la_s[g])
    );
  end

  assign cout_res_s = c_la_s[N_SLC];
  assign ovf_res_s  = c_la_s[N_SLC] ^ ctop_la_s[N_SLC-1];
`else
  logic [SLICE-1:0] f_sl_s;
  logic             cout_sl_s;
  logic             ctop_sl_s;

  carry_slice #(.SLICE(SLICE)) u_slice (
    .x    (x_r[idx_r*SLICE +: SLICE]),
    .y    (y_r[idx_r*SLICE +: SLICE]),
    .cin  (carry_r),
    .m    (m_r),
    .f    (f_sl_s),
    .cout (cout_sl_s),
    .ctop (ctop_sl_s)
  );

  // Splice the freshly resolved slice into the held result.
  always_comb begin
    f_res_s = f_r;
    f_res_s[idx_r*SLICE +: SLICE] = f_sl_s;
  end

  // On the top slice the slice carry-out is c[WIDTH] and ctop is c[WIDTH-1].
  assign cout_res_s = cout_sl_s;
  assign ovf_res_s  = cout_sl_s ^ ctop_sl_s;
`endif

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ACCEPT_ST;
        else          state_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture and the serial carry walk; DONE and IDLE hold f and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      f_r     <= {WIDTH{1'b0}};
      m_r     <= 1'b0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx_r   <= {IDX_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r     <= x;
            y_r     <= y;
            m_r     <= m;
            carry_r <= (m == MODE_LOGIC) ? 1'b0 : cin;
            idx_r   <= {IDX_BITS{1'b0}};
`ifdef ALU_LOOKAHEAD_EN
            f_r     <= f_res_s;
            cout_r  <= cout_res_s;
            ovf_r   <= ovf_res_s;
            zero_r  <= (f_res_s == {WIDTH{1'b0}});
`endif
          end
        end
        RUN: begin
          f_r     <= f_res_s;
          carry_r <= cout_res_s;
          idx_r   <= idx_r + IDX_BITS'(1);
          if (idx_r == LAST_IDX) begin
            cout_r <= cout_res_s;
            ovf_r  <= ovf_res_s;
            zero_r <= (f_res_s == {WIDTH{1'b0}});
          end
        end
        default: begin
          f_r <= f_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign f         = f_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_alu_carry_sum_unit.sv
// Self-checking bench for alu_carry_sum_unit: directed vectors, randomized ops against
// an integer-arithmetic reference, backpressure and mid-operation reset.
module tb_alu_carry_sum_unit;

  localparam int W = 8;
  localparam int S = 2;
`ifdef ALU_LOOKAHEAD_EN
  localparam int EXP_LAT = 0;      // result registered on the accepting edge itself
`else
  localparam int EXP_LAT = W / S;  // edges after the accepting edge
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         zero;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] f;
    logic       cout;
    logic       zero;
    logic       ovf;
  } res_t;

  alu_carry_sum_unit #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the stage adds a+b+cin when fed x = a^b, y = a&b.
  function automatic res_t ref_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int   u;
    int   s;
    res_t r;
    u      = int'(a) + int'(b) + int'(ci);
    s      = int'($signed(a)) + int'($signed(b)) + int'(ci);
    r.f    = u[7:0];
    r.cout = (u > 255);
    r.zero = (u[7:0] == 8'h00);
    r.ovf  = (s > 127) || (s < -128);
    return r;
  endfunction

  function automatic res_t ref_logic(input logic [7:0] xv);
    res_t r;
    r.f    = xv;
    r.cout = 1'b0;
    r.zero = (xv == 8'h00);
    r.ovf  = 1'b0;
    return r;
  endfunction

  // Offer one op, then wait (bounded) for out_valid; returns at #1 after the edge it rose on.
  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic ci,
                        input logic mv, output int lat, output res_t got);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    x = xv; y = yv; cin = ci; m = mv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {f, cout, zero, ovf};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = 8'h00; y = 8'h00; cin = 1'b0; m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    checks++;
    if ({f, cout, zero, ovf} !== 11'h000) begin
      errors++;
      $display("FAIL reset_out: f=%h cout=%b zero=%b ovf=%b, want all 0", f, cout, zero, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] dx [3];
    logic [7:0] dy [3];
    logic       dc [3];
    logic       dm [3];
    res_t       ex [3];
    res_t       got;
    int         lat;
    dx = '{8'h7E, 8'hFE, 8'hA5};
    dy = '{8'h01, 8'h01, 8'hFF};
    dc = '{1'b0, 1'b0, 1'b1};
    dm = '{1'b0, 1'b0, 1'b1};
    ex = '{'{8'h80, 1'b0, 1'b0, 1'b1}, '{8'h00, 1'b1, 1'b1, 1'b0}, '{8'hA5, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      run_op(dx[i], dy[i], dc[i], dm[i], lat, got);
      checks++;
      if (lat !== EXP_LAT) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d edges, want %0d", i, lat, EXP_LAT);
      end
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got f=%h c=%b z=%b v=%b, want f=%h c=%b z=%b v=%b", i,
                 got.f, got.cout, got.zero, got.ovf, ex[i].f, ex[i].cout, ex[i].zero, ex[i].ovf);
      end
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL dir%0d_release: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] xv;
    logic [7:0] yv;
    logic       ci;
    logic       mv;
    res_t       ex;
    res_t       got;
    int         lat;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      if (i % 4 == 3) begin
        mv = 1'b1; xv = a; yv = b; ex = ref_logic(a);
      end else begin
        mv = 1'b0; xv = a ^ b; yv = a & b; ex = ref_add(a, b, ci);
      end
      run_op(xv, yv, ci, mv, lat, got);
      checks++;
      if (got !== ex || lat !== EXP_LAT) begin
        errors++;
        $display("FAIL rand%0d: x=%h y=%h cin=%b m=%b got f=%h c=%b z=%b v=%b lat=%0d, want f=%h c=%b z=%b v=%b lat=%0d",
                 i, xv, yv, ci, mv, got.f, got.cout, got.zero, got.ovf, lat,
                 ex.f, ex.cout, ex.zero, ex.ovf, EXP_LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    res_t ex1;
    res_t ex2;
    res_t got;
    int   lat;
    ex1 = ref_add(8'h12, 8'h34, 1'b0);
    ex2 = ref_add(8'h80, 8'h80, 1'b1);
    out_ready = 1'b0;
    run_op(8'h12 ^ 8'h34, 8'h12 & 8'h34, 1'b0, 1'b0, lat, got);
    checks++;
    if (got !== ex1) begin
      errors++;
      $display("FAIL bp_first: got f=%h, want f=%h", got.f, ex1.f);
    end
    x = 8'h80 ^ 8'h80; y = 8'h80 & 8'h80; cin = 1'b1; m = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || {f, cout, zero, ovf} !== ex1) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b f=%h, want 1 0 f=%h",
                 i, out_valid, in_ready, f, ex1.f);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || f !== ex1.f) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b f=%h, want 1 0 f=%h",
               in_ready, out_valid, f, ex1.f);
    end
    run_op(8'h80 ^ 8'h80, 8'h80 & 8'h80, 1'b1, 1'b0, lat, got);
    checks++;
    if (got !== ex2 || lat !== EXP_LAT) begin
      errors++;
      $display("FAIL bp_second: got f=%h c=%b z=%b v=%b lat=%0d, want f=%h c=%b z=%b v=%b lat=%0d",
               got.f, got.cout, got.zero, got.ovf, lat, ex2.f, ex2.cout, ex2.zero, ex2.ovf, EXP_LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit   seen;
    res_t ex;
    res_t got;
    int   lat;
    out_ready = 1'b1;
    x = 8'hFF; y = 8'h00; cin = 1'b0; m = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || f !== 8'h00) begin
      errors++;
      $display("FAIL midrst_clear: out_valid=%b in_ready=%b f=%h, want 0 1 f=00", out_valid, in_ready, f);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_output: out_valid rose after reset, want it to stay 0");
    end
    ex = ref_add(8'h3C, 8'h5A, 1'b1);
    run_op(8'h3C ^ 8'h5A, 8'h3C & 8'h5A, 1'b1, 1'b0, lat, got);
    checks++;
    if (got !== ex || lat !== EXP_LAT) begin
      errors++;
      $display("FAIL midrst_next_op: got f=%h c=%b z=%b v=%b lat=%0d, want f=%h c=%b z=%b v=%b lat=%0d",
               got.f, got.cout, got.zero, got.ovf, lat, ex.f, ex.cout, ex.zero, ex.ovf, EXP_LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
